// File: rtl/store_sig_monitor.sv
// store_sig_monitor: watches the data-memory store bus beside Dmem.
// Stores into the signature window are queued in a small FIFO and drained
// through a valid/ready port. A store to the halt address, or the cycle
// budget running out, ends the run. The block then reports done once every
// queued word has been consumed.

module store_sig_monitor #(
    parameter int unsigned          DATA_W    = 32,
    parameter int unsigned          ADDR_W    = 32,
    parameter logic [ADDR_W-1:0]    SIG_BASE  = 32'h00000F00,
    parameter int unsigned          SIG_WORDS = 1,
    parameter logic [ADDR_W-1:0]    HALT_ADDR = 32'hCAFEBEEF,
    parameter int unsigned          DEPTH     = 16,
    parameter int unsigned          TIMEOUT   = 5000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              st_en,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [DATA_W-1:0] st_data,
    output logic              sig_valid,
    output logic [DATA_W-1:0] sig_data,
    input  logic              sig_ready,
    output logic              done,
    output logic              halted,
    output logic              timed_out,
    output logic              overflow,
    output logic [31:0]       cycle_count,
    output logic [15:0]       sig_count
);

    // FIFO pointers carry one extra wrap bit so full and empty are distinct.
    localparam int unsigned       PTR_W          = $clog2(DEPTH);
    localparam logic [PTR_W:0]    PTR_ONE        = (PTR_W + 1)'(1);
    // Window size in bytes, one bit wider than an address so the top of the
    // address space cannot wrap the comparison.
    localparam logic [ADDR_W:0]   SIG_SPAN       = (ADDR_W + 1)'(SIG_WORDS * 4);
    localparam logic [31:0]       LAST_RUN_CYCLE = 32'(TIMEOUT - 1);
    localparam logic [31:0]       CYCLE_MAX      = 32'hFFFF_FFFF;
    localparam logic [15:0]       SIG_MAX        = 16'hFFFF;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic                 set_halted;
    logic                 set_timed_out;

    logic [ADDR_W-1:0]    sig_offset;
    logic                 sig_hit;
    logic                 halt_hit;

    logic [DATA_W-1:0]    mem [DEPTH];
    logic [PTR_W:0]       wr_ptr;
    logic [PTR_W:0]       rd_ptr;
    logic                 fifo_empty;
    logic                 fifo_full;

    logic                 push_req;
    logic                 push;
    logic                 pop;
    logic                 drop;

    // Decode the store bus: window hits must be word aligned, halt is an exact match.
    always_comb begin
        sig_offset = st_addr - SIG_BASE;
        sig_hit    = st_en
                     && (st_addr >= SIG_BASE)
                     && ({1'b0, sig_offset} < SIG_SPAN)
                     && (st_addr[1:0] == 2'b00);
        halt_hit   = st_en && (st_addr == HALT_ADDR);
    end

    // FIFO status and handshake; a push into a full FIFO still succeeds when
    // the head leaves in the same cycle, since that slot is being freed.
    always_comb begin
        fifo_empty = (wr_ptr == rd_ptr);
        fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W])
                     && (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
        pop        = !fifo_empty && sig_ready;
        push_req   = (state == RUN) && sig_hit;
        push       = push_req && (!fifo_full || pop);
        drop       = push_req && fifo_full && !pop;
    end

    assign sig_valid = !fifo_empty;
    assign sig_data  = fifo_empty ? '0 : mem[rd_ptr[PTR_W-1:0]];
    assign done      = (state == DONE);

    // Next-state decode: halt beats the timeout when both land in the same cycle.
    always_comb begin
        state_next    = state;
        set_halted    = 1'b0;
        set_timed_out = 1'b0;
        case (state)
            RUN: begin
                if (halt_hit) begin
                    state_next = DRAIN;
                    set_halted = 1'b1;
                end else if (cycle_count == LAST_RUN_CYCLE) begin
                    state_next    = DRAIN;
                    set_timed_out = 1'b1;
                end
            end
            DRAIN: begin
                if (fifo_empty) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = DONE;
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    // State register plus the sticky end-of-test flags that ride with it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= RUN;
            halted    <= 1'b0;
            timed_out <= 1'b0;
        end else begin
            state <= state_next;
            if (set_halted) begin
                halted <= 1'b1;
            end
            if (set_timed_out) begin
                timed_out <= 1'b1;
            end
        end
    end

    // FIFO pointers; their width makes the wrap at DEPTH implicit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    // FIFO storage needs no reset: sig_data is forced to zero while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[PTR_W-1:0]] <= st_data;
        end
    end

    // Saturating run-cycle and accepted-signature counters plus sticky overflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle_count <= '0;
            sig_count   <= '0;
            overflow    <= 1'b0;
        end else begin
            if ((state == RUN) && (cycle_count != CYCLE_MAX)) begin
                cycle_count <= cycle_count + 32'd1;
            end
            if (push && (sig_count != SIG_MAX)) begin
                sig_count <= sig_count + 16'd1;
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_store_sig_monitor.sv
// tb_store_sig_monitor: randomized and directed stimulus for store_sig_monitor.
// A reference model predicts flags, counters and queue contents from the
// behavioural rules; a separate monitor compares the DUT at every falling edge
// and pops expected signature words whenever the DUT completes a handshake.

module tb_store_sig_monitor;

    localparam int          DATA_W    = 32;
    localparam int          ADDR_W    = 32;
    localparam logic [31:0] SIG_BASE  = 32'h00000F00;
    localparam int          SIG_WORDS = 4;
    localparam logic [31:0] HALT      = 32'hCAFEBEEF;
    localparam int          DEPTH     = 4;
    localparam int          TIMEOUT   = 40;

    logic              clk;
    logic              rst;
    logic              st_en;
    logic [ADDR_W-1:0] st_addr;
    logic [DATA_W-1:0] st_data;
    logic              sig_valid;
    logic [DATA_W-1:0] sig_data;
    logic              sig_ready;
    logic              done;
    logic              halted;
    logic              timed_out;
    logic              overflow;
    logic [31:0]       cycle_count;
    logic [15:0]       sig_count;

    store_sig_monitor #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .SIG_BASE (SIG_BASE),
        .SIG_WORDS(SIG_WORDS),
        .HALT_ADDR(HALT),
        .DEPTH    (DEPTH),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .st_en      (st_en),
        .st_addr    (st_addr),
        .st_data    (st_data),
        .sig_valid  (sig_valid),
        .sig_data   (sig_data),
        .sig_ready  (sig_ready),
        .done       (done),
        .halted     (halted),
        .timed_out  (timed_out),
        .overflow   (overflow),
        .cycle_count(cycle_count),
        .sig_count  (sig_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit monitorOn = 1'b0;

    // Model state as seen after the most recent rising edge.
    bit          mHalted, mTimedOut, mDone, mOverflow;
    int unsigned mCycles, mSigCount;
    int          mCount;
    // Model state predicted for the coming rising edge.
    bit          pHalted, pTimedOut, pDone, pOverflow, pPush;
    int unsigned pCycles, pSigCount;
    int          pCount;
    logic [31:0] pPushData;

    logic [31:0] expQ[$];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic bit isSigHit(input bit en, input logic [31:0] addr);
        return en && (addr >= SIG_BASE) && (addr < SIG_BASE + 32'(4 * SIG_WORDS)) && (addr % 4 == 0);
    endfunction

    task automatic clearModel();
        mHalted = 0; mTimedOut = 0; mDone = 0; mOverflow = 0;
        mCycles = 0; mSigCount = 0; mCount = 0;
        pHalted = 0; pTimedOut = 0; pDone = 0; pOverflow = 0; pPush = 0;
        pCycles = 0; pSigCount = 0; pCount = 0; pPushData = '0;
        expQ.delete();
    endtask

    // Predict the effect of the current bus inputs at the next rising edge.
    task automatic stepModel();
        bit running;
        bit pop;
        running   = !(mHalted || mTimedOut);
        pop       = sig_ready && (mCount > 0);
        pHalted   = mHalted;   pTimedOut = mTimedOut; pDone = mDone;
        pOverflow = mOverflow; pCycles   = mCycles;   pSigCount = mSigCount;
        pPush     = 0;
        if (running) begin
            pCycles = mCycles + 1;
            if (isSigHit(st_en, st_addr)) begin
                if (mCount < DEPTH || pop) begin
                    pPush     = 1;
                    pPushData = st_data;
                    pSigCount = mSigCount + 1;
                end else begin
                    pOverflow = 1;
                end
            end
            if (st_en && st_addr == HALT) pHalted = 1;
            else if (mCycles == TIMEOUT - 1) pTimedOut = 1;
        end else if (!mDone && mCount == 0) begin
            pDone = 1;
        end
        pCount = mCount - int'(pop) + int'(pPush);
    endtask

    task automatic commitModel();
        mHalted = pHalted; mTimedOut = pTimedOut; mDone = pDone; mOverflow = pOverflow;
        mCycles = pCycles; mSigCount = pSigCount; mCount = pCount;
        if (pPush) expQ.push_back(pPushData);
    endtask

    // Drive one cycle of bus activity and advance the model across the edge.
    task automatic applyStimulus(input bit en, input logic [31:0] addr, input logic [31:0] data, input bit ready);
        st_en     = en;
        st_addr   = addr;
        st_data   = data;
        sig_ready = ready;
        stepModel();
        @(posedge clk);
        #1;
        commitModel();
    endtask

    task automatic idleCycles(input int n, input bit ready);
        for (int i = 0; i < n; i++) applyStimulus(0, 32'h0, 32'h0, ready);
    endtask

    // Pull reset low between edges, confirm the asynchronous clear, then release.
    task automatic doReset();
        #1;
        rst = 1'b0;
        #1;
        checkOutput("rst_sig_valid",   32'(sig_valid),   32'h0);
        checkOutput("rst_sig_data",    sig_data,         32'h0);
        checkOutput("rst_done",        32'(done),        32'h0);
        checkOutput("rst_halted",      32'(halted),      32'h0);
        checkOutput("rst_timed_out",   32'(timed_out),   32'h0);
        checkOutput("rst_overflow",    32'(overflow),    32'h0);
        checkOutput("rst_cycle_count", cycle_count,      32'h0);
        checkOutput("rst_sig_count",   32'(sig_count),   32'h0);
        clearModel();
        st_en = 0; st_addr = '0; st_data = '0; sig_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // Scoreboard monitor: compare everything the DUT shows, pop on handshake.
    always @(negedge clk) begin
        if (monitorOn && rst === 1'b1) begin
            checkOutput("sig_valid",   32'(sig_valid), 32'(expQ.size() != 0));
            checkOutput("done",        32'(done),      32'(mDone));
            checkOutput("halted",      32'(halted),    32'(mHalted));
            checkOutput("timed_out",   32'(timed_out), 32'(mTimedOut));
            checkOutput("overflow",    32'(overflow),  32'(mOverflow));
            checkOutput("cycle_count", cycle_count,    mCycles);
            checkOutput("sig_count",   32'(sig_count), mSigCount);
            if (sig_valid === 1'b1 && sig_ready === 1'b1 && expQ.size() > 0) begin
                checkOutput("sig_data", sig_data, expQ.pop_front());
            end
        end
    end

    initial begin
        rst = 1'b1; st_en = 0; st_addr = '0; st_data = '0; sig_ready = 0;
        clearModel();
        doReset();
        monitorOn = 1'b1;

        $display("[TB] single signature store");
        applyStimulus(1, SIG_BASE, 32'hDEADBEEF, 1);
        idleCycles(3, 1);

        $display("[TB] window edges and misaligned address");
        doReset();
        applyStimulus(1, SIG_BASE + 32'h0,  32'h11111111, 0);
        applyStimulus(1, SIG_BASE + 32'h4,  32'h22222222, 0);
        applyStimulus(1, SIG_BASE + 32'hC,  32'h33333333, 0);
        applyStimulus(1, SIG_BASE + 32'h10, 32'h44444444, 0);
        applyStimulus(1, SIG_BASE + 32'h2,  32'h55555555, 0);
        idleCycles(5, 1);

        $display("[TB] overflow and push+pop while full");
        doReset();
        for (int i = 0; i < 5; i++) applyStimulus(1, SIG_BASE + 32'(4 * (i % 4)), 32'hA0 + 32'(i), 0);
        applyStimulus(1, SIG_BASE + 32'h8, 32'hBEEF0006, 1);
        idleCycles(6, 1);

        $display("[TB] halt then drain with stalls");
        doReset();
        applyStimulus(1, SIG_BASE,          32'h0000AAAA, 0);
        applyStimulus(1, SIG_BASE + 32'h4,  32'h0000BBBB, 0);
        applyStimulus(1, HALT,              32'h00000001, 0);
        idleCycles(3, 0);
        for (int i = 0; i < 4; i++) applyStimulus(1, SIG_BASE, 32'hC0 + 32'(i), 1);
        idleCycles(3, 1);

        $display("[TB] timeout with no halt");
        doReset();
        applyStimulus(1, SIG_BASE, 32'h0000CCCC, 0);
        idleCycles(TIMEOUT + 4, 0);
        idleCycles(4, 1);

        $display("[TB] halt on the timeout cycle");
        doReset();
        idleCycles(TIMEOUT - 1, 1);
        applyStimulus(1, HALT, 32'h0, 1);
        idleCycles(4, 1);

        $display("[TB] reset in the middle of draining");
        doReset();
        applyStimulus(1, SIG_BASE,         32'h12340001, 0);
        applyStimulus(1, SIG_BASE + 32'h4, 32'h12340002, 0);
        applyStimulus(1, HALT,             32'h0,        0);
        idleCycles(2, 0);
        doReset();
        applyStimulus(1, SIG_BASE + 32'h8, 32'h56780003, 1);
        idleCycles(3, 1);

        $display("[TB] randomized episodes");
        for (int ep = 0; ep < 25; ep++) begin
            int unsigned bias;
            doReset();
            bias = $urandom_range(0, 3);
            for (int c = 0; c < 300 && !mDone; c++) begin
                int unsigned r;
                logic [31:0] addr;
                bit en;
                bit ready;
                r = $urandom_range(0, 59);
                if (r == 0)       addr = HALT;
                else if (r < 30)  addr = SIG_BASE + 32'(4 * $urandom_range(0, SIG_WORDS));
                else if (r < 36)  addr = SIG_BASE + 32'($urandom_range(1, 3)) + 32'(4 * $urandom_range(0, 3));
                else              addr = $urandom;
                en    = ($urandom_range(0, 3) != 0);
                ready = (mHalted || mTimedOut) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 3) < bias);
                applyStimulus(en, addr, $urandom, ready);
            end
            checkOutput("episode_done", 32'(done), 32'h1);
            idleCycles(2, 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
